sextium_mem_arbiter: RTL
========================

Name: sextium_mem_arbiter

Overview:
Two-requester arbiter sharing one synchronous-strobe memory port between the Sextium core (port 0) and a loader/DMA engine (port 1). It uses a req/ack handshake per port and round-robin fairness on contention. It latches the winning request and holds the memory strobes for a fixed, parameterised number of wait states. It returns registered read data with a one-cycle ack.

Parameters:
WIDTH, 16, data and address width in bits
WAIT_STATES, 1, extra cycles memory strobes are held beyond the first (legal 0..15)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  port 0 request; held high until ack0
we0  input  1  port 0 direction: 1 = write, 0 = read
addr0  input  WIDTH  port 0 address
wdata0  input  WIDTH  port 0 write data
ack0  output  1  port 0 completion pulse, one cycle
req1  input  1  port 1 request
we1  input  1  port 1 direction
addr1  input  WIDTH  port 1 address
wdata1  input  WIDTH  port 1 write data
ack1  output  1  port 1 completion pulse
rdata  output  WIDTH  registered read data; valid in the ack cycle, held until the next capture
mem_addr  output  WIDTH  memory address (latched)
mem_wdata  output  WIDTH  memory write data (latched)
mem_rdata  input  WIDTH  memory read data
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
busy  output  1  high in ACCESS and ACK
owner  output  1  port of the current or most recent grant

Behaviour:
- Reset values: state IDLE; ack0, ack1, mem_read, mem_write, busy = 0; rdata, mem_addr, mem_wdata = 0; owner = 0; last = 1. Because last = 1, port 0 wins the first contention.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port != last.
  - On grant at edge k:
    - latch addr, we and wdata into mem_addr, mem_wdata and a we register;
    - owner = last = winner;
    - cnt = WAIT_STATES;
    - go to ACCESS.
- ACCESS:
  - mem_read = !we_latched and mem_write = we_latched, combinational from state, asserted for exactly WAIT_STATES+1 cycles (edges k..k+WAIT_STATES).
  - Each edge: if cnt != 0, cnt decrements. If cnt == 0, rdata <= mem_rdata when reading (unchanged on write) and go to ACK.
- ACK: ack[owner] = 1 for exactly one cycle, strobes low, then IDLE.
- Latency: req sampled at edge k, ack high during the cycle after edge k+WAIT_STATES+1. Minimum transaction spacing is WAIT_STATES+3 cycles.
- Handshake rules:
  - Requester holds req, we, addr and wdata stable until ack.
  - Requester must drop req before the first IDLE sampling edge (k+WAIT_STATES+3), otherwise a new transaction starts.
  - req/addr/we/wdata changes during ACCESS/ACK are ignored (values are latched).
  - Deasserting req mid-transaction does not abort it; ack still pulses.
- Simultaneous events: a req of the non-owner arriving during ACCESS/ACK waits; it wins at the next IDLE if both ports are requesting. Strict alternation under continuous dual requests.
- Never: both strobes high, both acks high, an ack outside ACK.
- cnt width is 4 bits; WAIT_STATES = 0 gives a single-cycle strobe.
- Reset mid-operation: at the reset edge, strobes, acks and busy drop; the transaction is abandoned with no ack; last returns to 1.

Test Plan:
- WAIT_STATES=1, port 0 read addr 0x0010, mem_rdata=0xBEEF -> mem_read high 2 cycles with mem_addr=0x0010, ack0 one cycle later with rdata=0xBEEF, mem_write never high.
- Port 1 write addr 0x1234 data 0x00FF -> mem_write high 2 cycles, mem_addr=0x1234, mem_wdata=0x00FF, ack1 pulses, rdata unchanged, owner=1.
- req0 and req1 asserted at the same edge after reset, both held -> port 0 served first, then port 1, then port 0; acks alternate, spacing 4 cycles each.
- Port 0 drops req in its ack cycle while port 1 requests continuously -> port 1 granted at the next IDLE edge; verify no duplicate port-0 transaction.
- Reset asserted in the second ACCESS cycle -> next cycle mem_read=0, busy=0, no ack; a subsequent dual request grants port 0.
- WAIT_STATES=0, back-to-back port 1 reads to 0x0001 and 0x0002 -> 1-cycle strobes, acks 3 cycles apart, rdata tracks mem_rdata per access.

Source files
------------

// File: rtl/sextium_mem_arbiter_if.sv
// Bus bundle between the two requesters, the shared memory port and the arbiter.
// The arbiter uses the slave view; the requester/memory side uses the master view.
interface sextium_mem_arbiter_if #(
   parameter int WIDTH = 16
);
   logic             req0;
   logic             we0;
   logic [WIDTH-1:0] addr0;
   logic [WIDTH-1:0] wdata0;
   logic             ack0;
   logic             req1;
   logic             we1;
   logic [WIDTH-1:0] addr1;
   logic [WIDTH-1:0] wdata1;
   logic             ack1;
   logic [WIDTH-1:0] rdata;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_read;
   logic             mem_write;
   logic             busy;
   logic             owner;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_rdata,
      output ack0, ack1, rdata,
      output mem_addr, mem_wdata, mem_read, mem_write,
      output busy, owner
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_rdata,
      input  ack0, ack1, rdata,
      input  mem_addr, mem_wdata, mem_read, mem_write,
      input  busy, owner
   );
endinterface

// File: rtl/sextium_mem_arbiter.sv
// Round-robin arbiter sharing one strobed memory port between the Sextium core
// (port 0) and the loader/DMA engine (port 1), with fixed wait states and a one-cycle ack.
module sextium_mem_arbiter #(
   parameter int WIDTH       = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic                 clock,
   input  logic                 reset,
   sextium_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ACK
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES);

   state_t           state;
   state_t           state_next;
   logic [3:0]       cnt;
   logic             we_q;
   logic             last;
   logic             owner_q;
   logic [WIDTH-1:0] mem_addr_q;
   logic [WIDTH-1:0] mem_wdata_q;
   logic [WIDTH-1:0] rdata_q;

   logic any_req;
   logic winner;

   // On contention the port that did not win last time is served.
   assign any_req = bus.req0 | bus.req1;
   assign winner  = (bus.req0 & bus.req1) ? ~last : bus.req1;

   // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (any_req) state_next = ACCESS;
         ACCESS:  if (cnt == 4'd0) state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt         <= 4'd0;
         we_q        <= 1'b0;
         last        <= 1'b1;
         owner_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  cnt         <= CNT_INIT;
                  owner_q     <= winner;
                  last        <= winner;
                  we_q        <= winner ? bus.we1    : bus.we0;
                  mem_addr_q  <= winner ? bus.addr1  : bus.addr0;
                  mem_wdata_q <= winner ? bus.wdata1 : bus.wdata0;
               end
            end
            ACCESS: begin
               // The final strobe cycle doubles as the read-data capture point.
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else if (!we_q) begin
                  rdata_q <= bus.mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.ack0      = 1'b0;
      bus.ack1      = 1'b0;
      bus.busy      = 1'b0;
      case (state)
         ACCESS: begin
            bus.mem_read  = ~we_q;
            bus.mem_write = we_q;
            bus.busy      = 1'b1;
         end
         ACK: begin
            bus.ack0 = ~owner_q;
            bus.ack1 = owner_q;
            bus.busy = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.rdata     = rdata_q;
   assign bus.owner     = owner_q;

endmodule
